// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode encodings, flag bit indices and operand-use helpers
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_SHL = 4'h6;
   localparam logic [3:0] OP_SHR = 4'h7;
   localparam logic [3:0] OP_ASR = 4'h8;
   localparam logic [3:0] OP_LDI = 4'hF;

   // Bit positions inside the {Z,C,N,V} flag vector
   localparam int FLG_Z = 3;
   localparam int FLG_C = 2;
   localparam int FLG_N = 1;
   localparam int FLG_V = 0;

   // LDI takes its value from the immediate, so it reads no register
   function automatic logic uses_rs1(input logic [3:0] op);
      return op != OP_LDI;
   endfunction

   // NOT is unary and LDI reads nothing, so neither depends on rs2
   function automatic logic uses_rs2(input logic [3:0] op);
      return (op != OP_LDI) && (op != OP_NOT);
   endfunction

endpackage

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - three-stage pipelined ALU: input capture, compute, output register
module alu_pipe
   import alu_pkg::*;
#(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   op,
   output logic [N-1:0] result,
   output logic         z,
   output logic         c,
   output logic         n,
   output logic         v
);

   localparam int SW = $clog2(N);

   logic [N-1:0] s1_a, s1_b;
   logic [3:0]   s1_op;
   logic [N:0]   sum;
   logic [N-1:0] r;
   logic         cf, vf;
   logic [N-1:0] s2_r, s3_r;
   logic [3:0]   s2_f, s3_f;

   // Stage 1: capture operands and opcode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_a  <= '0;
         s1_b  <= '0;
         s1_op <= OP_ADD;
      end else begin
         s1_a  <= a;
         s1_b  <= b;
         s1_op <= op;
      end
   end

   // Combinational operation on the captured operands; C is borrow for SUB
   always_comb begin
      sum = '0;
      r   = '0;
      cf  = 1'b0;
      vf  = 1'b0;
      case (s1_op)
         OP_ADD: begin
            sum = {1'b0, s1_a} + {1'b0, s1_b};
            r   = sum[N-1:0];
            cf  = sum[N];
            vf  = (s1_a[N-1] == s1_b[N-1]) && (r[N-1] != s1_a[N-1]);
         end
         OP_SUB: begin
            sum = {1'b0, s1_a} - {1'b0, s1_b};
            r   = sum[N-1:0];
            cf  = sum[N];
            vf  = (s1_a[N-1] != s1_b[N-1]) && (r[N-1] != s1_a[N-1]);
         end
         OP_AND:  r = s1_a & s1_b;
         OP_OR:   r = s1_a | s1_b;
         OP_XOR:  r = s1_a ^ s1_b;
         OP_NOT:  r = ~s1_a;
         OP_SHL:  r = s1_a << s1_b[SW-1:0];
         OP_SHR:  r = s1_a >> s1_b[SW-1:0];
         OP_ASR:  r = $signed(s1_a) >>> s1_b[SW-1:0];
         default: r = '0;
      endcase
   end

   // Stages 2 and 3: result and flags registered twice
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_r <= '0;
         s2_f <= '0;
         s3_r <= '0;
         s3_f <= '0;
      end else begin
         s2_r <= r;
         s2_f <= {(r == '0), cf, r[N-1], vf};
         s3_r <= s2_r;
         s3_f <= s2_f;
      end
   end

   assign result = s3_r;
   assign z      = s3_f[3];
   assign c      = s3_f[2];
   assign n      = s3_f[1];
   assign v      = s3_f[0];

endmodule

// File: rtl/regfile_3r1w.sv
// rtl/regfile_3r1w.sv - register file, two operand read ports, one debug read port, one write port
module regfile_3r1w #(
   parameter int N    = 16,
   parameter int REGS = 8,
   parameter int AW   = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [N-1:0]  wdata,
   input  logic [AW-1:0] raddr1,
   output logic [N-1:0]  rdata1,
   input  logic [AW-1:0] raddr2,
   output logic [N-1:0]  rdata2,
   input  logic [AW-1:0] raddr3,
   output logic [N-1:0]  rdata3
);

   logic [N-1:0] regs [REGS];

   // Single write port; every register clears on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];
   assign rdata3 = regs[raddr3];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - in-order ALU issue/writeback controller with scoreboard; BYPASS_EN forwards the writeback result
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int  N       = 16,
   parameter int  REGS    = 8,
   parameter int  ALU_LAT = 3,
   localparam int AW      = $clog2(REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [3:0]    instr_op,
   input  logic [AW-1:0] instr_rd,
   input  logic [AW-1:0] instr_rs1,
   input  logic [AW-1:0] instr_rs2,
   input  logic [N-1:0]  instr_imm,
   output logic [N-1:0]  alu_a,
   output logic [N-1:0]  alu_b,
   output logic [3:0]    alu_op,
   input  logic [N-1:0]  alu_result,
   input  logic          alu_z,
   input  logic          alu_c,
   input  logic          alu_n,
   input  logic          alu_v,
   output logic          wb_valid,
   output logic [AW-1:0] wb_addr,
   output logic [N-1:0]  wb_data,
   output logic [3:0]    flags,
   output logic          busy,
   input  logic [AW-1:0] dbg_addr,
   output logic [N-1:0]  dbg_data
);

   logic             is_ldi;
   logic             issue;
   logic [N-1:0]     rf_a, rf_b;
   logic [N-1:0]     opnd_a, opnd_b;
   logic [REGS-1:0]  pending, pending_nxt, hazard;
   logic [ALU_LAT:0] sr_valid, sr_ldi;
   logic [AW-1:0]    sr_rd [ALU_LAT+1];
   logic             tail_valid, tail_ldi;
   logic [AW-1:0]    tail_rd;
   logic [3:0]       flag_in;

   assign tail_valid = sr_valid[ALU_LAT];
   assign tail_ldi   = sr_ldi[ALU_LAT];
   assign tail_rd    = sr_rd[ALU_LAT];
   assign is_ldi     = (instr_op == OP_LDI);

   regfile_3r1w #(.N(N), .REGS(REGS), .AW(AW)) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (tail_valid),
      .waddr  (tail_rd),
      .wdata  (alu_result),
      .raddr1 (instr_rs1),
      .rdata1 (rf_a),
      .raddr2 (instr_rs2),
      .rdata2 (rf_b),
      .raddr3 (dbg_addr),
      .rdata3 (dbg_data)
   );

`ifdef BYPASS_EN
   logic [REGS-1:0] tail_mask;

   // The register retiring this cycle is already on alu_result, so it is not a hazard
   always_comb begin
      tail_mask = '0;
      if (tail_valid) tail_mask[tail_rd] = 1'b1;
   end

   assign hazard = pending & ~tail_mask;
   assign opnd_a = (tail_valid && (tail_rd == instr_rs1)) ? alu_result : rf_a;
   assign opnd_b = (tail_valid && (tail_rd == instr_rs2)) ? alu_result : rf_b;
`else
   assign hazard = pending;
   assign opnd_a = rf_a;
   assign opnd_b = rf_b;
`endif

   assign instr_ready = !((uses_rs1(instr_op) && hazard[instr_rs1]) ||
                          (uses_rs2(instr_op) && hazard[instr_rs2]) ||
                          hazard[instr_rd]);
   assign issue       = instr_valid && instr_ready;

   // Operand registers feeding the ALU; LDI is an ADD of the immediate and zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
      end else if (issue) begin
         alu_a  <= is_ldi ? instr_imm : opnd_a;
         alu_b  <= is_ldi ? '0 : opnd_b;
         alu_op <= is_ldi ? OP_ADD : instr_op;
      end
   end

   // Tag pipe tracks each op alongside the ALU; a non-issue cycle inserts a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_valid <= '0;
         sr_ldi   <= '0;
         for (int i = 0; i <= ALU_LAT; i++) sr_rd[i] <= '0;
      end else begin
         sr_valid <= {sr_valid[ALU_LAT-1:0], issue};
         sr_ldi   <= {sr_ldi[ALU_LAT-1:0], issue && is_ldi};
         sr_rd[0] <= instr_rd;
         for (int i = 1; i <= ALU_LAT; i++) sr_rd[i] <= sr_rd[i-1];
      end
   end

   // Scoreboard update: retire clears first so a same-edge re-issue leaves the bit set
   always_comb begin
      pending_nxt = pending;
      if (tail_valid) pending_nxt[tail_rd] = 1'b0;
      if (issue)      pending_nxt[instr_rd] = 1'b1;
   end

   // Scoreboard register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= pending_nxt;
   end

   // Pack ALU flags into architectural order
   always_comb begin
      flag_in        = '0;
      flag_in[FLG_Z] = alu_z;
      flag_in[FLG_C] = alu_c;
      flag_in[FLG_N] = alu_n;
      flag_in[FLG_V] = alu_v;
   end

   // Architectural flags follow every retiring op except LDI
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        flags <= '0;
      else if (tail_valid && !tail_ldi) flags <= flag_in;
   end

   assign wb_valid = tail_valid;
   assign wb_addr  = tail_rd;
   assign wb_data  = alu_result;
   assign busy     = |pending;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl driving a real alu_pipe
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   localparam int N    = 16;
   localparam int REGS = 8;
   localparam int LAT  = 3;
`ifdef BYPASS_EN
   localparam bit BYP       = 1'b1;
   localparam int DEP_STALL = 3;
`else
   localparam bit BYP       = 1'b0;
   localparam int DEP_STALL = 4;
`endif

   logic        clk, rst;
   logic        instr_valid, instr_ready;
   logic [3:0]  instr_op;
   logic [2:0]  instr_rd, instr_rs1, instr_rs2;
   logic [15:0] instr_imm;
   logic [15:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   logic        alu_z, alu_c, alu_n, alu_v;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic [3:0]  flags;
   logic        busy;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   alu_issue_ctrl #(.N(N), .REGS(REGS), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
      .instr_imm(instr_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_z(alu_z), .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flags(flags), .busy(busy),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   alu_pipe #(.N(N)) u_alu (
      .clk(clk), .rst(rst), .a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result),
      .z(alu_z), .c(alu_c), .n(alu_n), .v(alu_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          due;
      logic [2:0]  rd;
      logic [15:0] data;
      logic [3:0]  flg;
      bit          ldi;
   } wb_t;

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  rd, rs1, rs2;
      logic [15:0] imm;
      int          stall;
      bit          drain;
      logic [15:0] val;
      logic [3:0]  fl, fmask;
   } vec_t;

   logic [15:0] aregs [8];
   logic [15:0] cregs [8];
   logic [3:0]  cflags;
   int          wb_edge [8];
   int          edge_cnt = 0;
   wb_t         q[$];
   vec_t        tbl [11];
   logic [3:0]  ops_tab [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic [3:0] f);
      int ua, ub, ur, sa, sb, sr, sh;
      logic c, v;
      ua = int'(a);  ub = int'(b);
      sa = int'($signed(a));  sb = int'($signed(b));
      sh = ub % 16;
      ur = 0;  sr = 0;  c = 1'b0;  v = 1'b0;
      case (op)
         OP_ADD: begin ur = ua + ub; sr = sa + sb; c = (ur > 65535); v = (sr > 32767) || (sr < -32768); end
         OP_SUB: begin ur = ua - ub; sr = sa - sb; c = (ua < ub);    v = (sr > 32767) || (sr < -32768); end
         OP_AND: ur = ua & ub;
         OP_OR:  ur = ua | ub;
         OP_XOR: ur = ua ^ ub;
         OP_NOT: ur = 65535 - ua;
         OP_SHL: ur = ua << sh;
         OP_SHR: ur = ua >> sh;
         OP_ASR: ur = sa >>> sh;
         default: ur = 0;
      endcase
      r = ur[15:0];
      f = {(r == 16'h0), c, r[15], v};
   endfunction

   function automatic bit reg_ok(input logic [2:0] r, input int e);
      return BYP ? (e >= wb_edge[r]) : (e > wb_edge[r]);
   endfunction

   function automatic bit model_ready(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2, input int e);
      bit ok;
      ok = reg_ok(rd, e);
      if (op != OP_LDI && !reg_ok(rs1, e)) ok = 1'b0;
      if (op != OP_LDI && op != OP_NOT && !reg_ok(rs2, e)) ok = 1'b0;
      return ok;
   endfunction

   // One clock cycle: drive, check against model, advance past posedge, land on negedge
   task automatic cycle(input bit v, input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [15:0] imm, output bit issued);
      int e;
      bit er;
      wb_t w;
      logic [15:0] r;
      logic [3:0] f;
      instr_valid = v;  instr_op = op;  instr_rd = rd;
      instr_rs1 = rs1;  instr_rs2 = rs2;  instr_imm = imm;
      dbg_addr = 3'($urandom_range(0, 7));
      #1;
      e  = edge_cnt + 1;
      er = model_ready(op, rd, rs1, rs2, e);
      chk("instr_ready", instr_ready, er);
      if (q.size() > 0 && q[0].due == e) begin
         chk("wb_valid", wb_valid, 1);
         chk("wb_addr", wb_addr, q[0].rd);
         chk("wb_data", wb_data, q[0].data);
      end else begin
         chk("wb_valid", wb_valid, 0);
      end
      chk("busy", busy, q.size() != 0);
      chk("flags", flags, cflags);
      chk("dbg_data", dbg_data, cregs[dbg_addr]);
      issued = v && er;
      if (issued) begin
         if (op == OP_LDI) begin r = imm; f = 4'h0; end
         else ref_alu(op, aregs[rs1], aregs[rs2], r, f);
         aregs[rd]   = r;
         wb_edge[rd] = e + LAT + 1;
         w.due = e + LAT + 1;  w.rd = rd;  w.data = r;  w.flg = f;  w.ldi = (op == OP_LDI);
         q.push_back(w);
      end
      @(posedge clk);
      edge_cnt++;
      while (q.size() > 0 && q[0].due == edge_cnt) begin
         cregs[q[0].rd] = q[0].data;
         if (!q[0].ldi) cflags = q[0].flg;
         void'(q.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      bit d;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         cycle(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 16'h0, d);
         n++;
      end
      chk("drain_timeout", q.size(), 0);
   endtask

   // Asynchronous reset asserted mid-cycle; checks immediate and post-reset state
   task automatic do_reset();
      rst = 1'b1;
      instr_valid = 1'b0;
      #1;
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_busy", busy, 0);
      q.delete();
      for (int i = 0; i < 8; i++) begin
         aregs[i] = '0;  cregs[i] = '0;  wb_edge[i] = -1000;
      end
      cflags = 4'h0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      instr_op = OP_ADD;  instr_rd = 3'd0;  instr_rs1 = 3'd0;  instr_rs2 = 3'd0;
      #1;
      chk("rst_ready", instr_ready, 1);
      chk("rst_busy_after", busy, 0);
      chk("rst_flags", flags, 0);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk("rst_dbg", dbg_data, 0);
      end
      @(negedge clk);
   endtask

   initial begin
      bit iss;
      int tries;
      rst = 1'b1;  instr_valid = 1'b0;  instr_op = OP_ADD;  instr_rd = '0;
      instr_rs1 = '0;  instr_rs2 = '0;  instr_imm = '0;  dbg_addr = '0;

      //          op      rd    rs1   rs2   imm        stall      drn  val        fl     fmask
      tbl[0]  = '{OP_LDI, 3'd1, 3'd0, 3'd0, 16'd5,     0,         1'b0, 16'd5,     4'h0, 4'h0};
      tbl[1]  = '{OP_LDI, 3'd2, 3'd0, 3'd0, 16'd3,     0,         1'b0, 16'd3,     4'h0, 4'h0};
      tbl[2]  = '{OP_ADD, 3'd3, 3'd1, 3'd2, 16'd0,     DEP_STALL, 1'b1, 16'd8,     4'h0, 4'hF};
      tbl[3]  = '{OP_LDI, 3'd4, 3'd0, 3'd0, 16'h7FFF,  0,         1'b0, 16'h7FFF,  4'h0, 4'h0};
      tbl[4]  = '{OP_LDI, 3'd5, 3'd0, 3'd0, 16'd1,     0,         1'b0, 16'd1,     4'h0, 4'h0};
      tbl[5]  = '{OP_ADD, 3'd6, 3'd4, 3'd5, 16'd0,     DEP_STALL, 1'b1, 16'h8000,  4'h3, 4'hF};
      tbl[6]  = '{OP_SUB, 3'd7, 3'd1, 3'd1, 16'd0,     0,         1'b1, 16'h0,     4'h8, 4'hB};
      tbl[7]  = '{OP_XOR, 3'd3, 3'd3, 3'd3, 16'd0,     0,         1'b1, 16'h0,     4'h8, 4'hA};
      tbl[8]  = '{OP_AND, 3'd0, 3'd4, 3'd5, 16'd0,     0,         1'b1, 16'h1,     4'h0, 4'hA};
      tbl[9]  = '{OP_NOT, 3'd1, 3'd5, 3'd7, 16'd0,     0,         1'b1, 16'hFFFE,  4'h2, 4'hA};
      tbl[10] = '{OP_SUB, 3'd2, 3'd5, 3'd4, 16'd0,     0,         1'b1, 16'h8002,  4'h2, 4'hB};

      ops_tab = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_ASR, OP_LDI};

      @(negedge clk);
      do_reset();

      // Directed table: stall counts, results and flags
      for (int i = 0; i < 11; i++) begin
         tries = 0;
         iss = 1'b0;
         while (!iss && tries < 20) begin
            cycle(1'b1, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, iss);
            if (!iss) tries++;
         end
         chk("stall_cycles", tries, tbl[i].stall);
         if (tbl[i].drain) begin
            drain();
            dbg_addr = tbl[i].rd;
            #1;
            chk("tbl_value", dbg_data, tbl[i].val);
            chk("tbl_flags", flags & tbl[i].fmask, tbl[i].fl & tbl[i].fmask);
         end
      end

      // Reset two cycles after an issue: the op must never write back
      tries = 0;
      iss = 1'b0;
      while (!iss && tries < 20) begin
         cycle(1'b1, OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0, iss);
         tries++;
      end
      chk("midflight_issue", iss, 1);
      cycle(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 16'h0, iss);
      cycle(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 16'h0, iss);
      do_reset();
      for (int i = 0; i < 6; i++) cycle(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 16'h0, iss);

      // Random instruction stream against the model
      for (int i = 0; i < 500; i++) begin
         cycle($urandom_range(0, 9) < 7, ops_tab[$urandom_range(0, 9)],
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               16'($urandom), iss);
      end
      drain();
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk("final_reg", dbg_data, cregs[i]);
      end
      chk("final_flags", flags, cflags);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
